score_tracker: RTL

- Parametrised game score engine: per-run tick-based score with bonus adds, pause and saturation.
- On run end, commits the final score into a HIST_DEPTH-entry ring history and a sorted top-HS_N high-score table.
- Sits between the game-control FSM (start/pause/lose/bonus pulses) and the display/menu logic, which reads both tables.

---
 rtl/score_pkg.sv | 39 +++
 rtl/score_bcd_conv.sv | 79 +++++++
 rtl/score_tracker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
//   Shared definitions for the score_tracker block.
//   - state_t     : state encoding visible on score_tracker.state_o
//   - tick_div    : clock cycles per score tick
//   - sat_add     : unsigned add that clamps at the all-ones value of a width
//   - bcd_digits  : decimal digits needed to show a w-bit unsigned value
// -----------------------------------------------------------------------------
package score_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_COMMIT = 3'd3
    } state_t;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Operands are zero-extended to 33 bits so the carry out is never lost;
    // valid for widths up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

    // ceil(w * log10(2)) with log10(2) taken as 0.302.
    function automatic int bcd_digits(input int w);
        return (w * 302 + 999) / 1000;
    endfunction

endpackage

// File: rtl/score_bcd_conv.sv
// -----------------------------------------------------------------------------
// score_bcd_conv
//   Iterative double-dabble binary-to-BCD converter. A new conversion starts
//   whenever bin_i differs from the value last captured; the result appears
//   W+1 cycles after the last change of bin_i.
//
// Ports
//   Clock    in   system clock
//   reset    in   synchronous, active-low reset
//   bin_i    in   W-bit binary value to convert
//   bcd_o    out  packed BCD digits, least significant digit in bits [3:0]
//   valid_o  out  high when bcd_o matches the current bin_i
// -----------------------------------------------------------------------------
module score_bcd_conv
    import score_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                         Clock,
    input  logic                         reset,
    input  logic [W-1:0]                 bin_i,
    output logic [4*bcd_digits(W)-1:0]   bcd_o,
    output logic                         valid_o
);

    localparam int DIGITS = bcd_digits(W);
    localparam int BW     = 4 * DIGITS;
    localparam int CW     = $clog2(W + 1);

    logic [W-1:0]    bin_q;
    logic [W-1:0]    last_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   bcd_adj;
    logic [BW+W-1:0] shifted;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    // Add 3 to every digit that is 5 or more before the shift doubles it.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, bin_q} << 1;

    always_ff @(posedge Clock) begin
        if (!reset) begin
            bin_q   <= '0;
            last_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            bcd_o   <= '0;
            valid_o <= 1'b0;
        end else if ((bin_i != last_q) || (!busy_q && !valid_o)) begin
            // The second term kicks off the first conversion after reset.
            last_q  <= bin_i;
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= CW'(W);
            busy_q  <= 1'b1;
            valid_o <= 1'b0;
        end else if (busy_q) begin
            bcd_q <= shifted[BW+W-1:W];
            bin_q <= shifted[W-1:0];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q  <= 1'b0;
                valid_o <= 1'b1;
                bcd_o   <= shifted[BW+W-1:W];
            end
        end
    end

endmodule

// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//   Game score engine. While a run is active the score rises by one every
//   TICK_DIV clocks plus any bonus amounts, saturating at all-ones. When the
//   run is lost the final score goes into a HIST_DEPTH-entry ring history
//   and, through a one-step-per-cycle insertion walk, into a sorted top-HS_N
//   table. The commit takes HS_N+1 cycles.
//
// Ports
//   Clock           in   system clock
//   reset           in   synchronous, active-low reset
//   start_i         in   pulse, begin a run (IDLE only)
//   pause_i         in   level, freeze scoring while high
//   lose_i          in   pulse, end the run (RUN/PAUSE)
//   bonus_i         in   pulse, add bonus_amt_i (RUN only)
//   bonus_amt_i     in   8-bit bonus value
//   score_o         out  live score; holds the committed value until next start
//   state_o         out  IDLE=0 RUN=1 PAUSE=2 COMMIT=3
//   hist_rd_addr_i  in   history read address, 0 = most recent run
//   hist_rd_data_o  out  history read data, one cycle after the address
//   hist_count_o    out  number of valid history entries
//   hs_rd_idx_i     in   high-score index, 0 = best
//   hs_rd_data_o    out  high-score read data, combinational
//   commit_done_o   out  one-cycle pulse as the commit finishes
//   new_hs_o        out  one-cycle pulse with commit_done_o when the run beat
//                        the previous best
//   score_bcd_o     out  BCD copy of score_o        (SCORE_BCD_EN only)
//   bcd_valid_o     out  score_bcd_o is up to date  (SCORE_BCD_EN only)
//
// Build option
//   SCORE_BCD_EN : when defined, adds the BCD outputs and the converter.
// -----------------------------------------------------------------------------
module score_tracker
    import score_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int TICK_HZ         = 10,
    parameter int SCORE_W         = 16,
    parameter int HIST_DEPTH      = 16,
    parameter int HS_N            = 4
) (
    input  logic                          Clock,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic                          pause_i,
    input  logic                          lose_i,
    input  logic                          bonus_i,
    input  logic [7:0]                    bonus_amt_i,
    output logic [SCORE_W-1:0]            score_o,
    output logic [2:0]                    state_o,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_addr_i,
    output logic [SCORE_W-1:0]            hist_rd_data_o,
    output logic [$clog2(HIST_DEPTH):0]   hist_count_o,
    input  logic [$clog2(HS_N)-1:0]       hs_rd_idx_i,
    output logic [SCORE_W-1:0]            hs_rd_data_o,
`ifdef SCORE_BCD_EN
    output logic [4*bcd_digits(SCORE_W)-1:0] score_bcd_o,
    output logic                          bcd_valid_o,
`endif
    output logic                          commit_done_o,
    output logic                          new_hs_o
);

    localparam int TICK_DIV = tick_div(CLOCK_FREQUENCY, TICK_HZ);
    localparam int PW       = $clog2(TICK_DIV);
    localparam int HA_W     = $clog2(HIST_DEPTH);
    localparam int HI_W     = $clog2(HS_N);
    localparam logic [PW-1:0]   PRESC_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [HI_W-1:0] K_TOP        = HI_W'(HS_N - 1);

    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       presc_q;
    logic [SCORE_W-1:0]  score_q;
    logic [SCORE_W-1:0]  score_sum;
    logic [8:0]          add_amt;
    logic                tick;

    // Commit walk: c0_q marks the first commit cycle, k_q is the cursor.
    logic                c0_q;
    logic [HI_W-1:0]     k_q;
    logic [HI_W-1:0]     k_next;
    logic                placed_q;
    logic                walk_last;

    logic [SCORE_W-1:0]  hist_mem [HIST_DEPTH];
    logic [HA_W-1:0]     wr_ptr_q;
    logic [HA_W:0]       hist_cnt_q;
    logic [HA_W-1:0]     rd_slot;
    logic [SCORE_W-1:0]  hist_rd_q;

    logic [SCORE_W-1:0]  hs_tab [HS_N];
    logic                commit_done_q;
    logic                new_hs_q;

    assign tick      = (presc_q == '0);
    assign add_amt   = {8'd0, tick} + (bonus_i ? {1'b0, bonus_amt_i} : 9'd0);
    assign score_sum = SCORE_W'(sat_add(32'(score_q), 32'(add_amt), SCORE_W));
    assign walk_last = (state_q == ST_COMMIT) && !c0_q && (k_q == '0);
    assign k_next    = k_q + HI_W'(1);
    assign rd_slot   = wr_ptr_q - HA_W'(1) - hist_rd_addr_i;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge Clock) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (lose_i)       state_d = ST_COMMIT;
                else if (pause_i) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (lose_i)        state_d = ST_COMMIT;
                else if (!pause_i) state_d = ST_RUN;
            end
            ST_COMMIT: if (walk_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------ score and prescaler
    always_ff @(posedge Clock) begin
        if (!reset) begin
            score_q <= '0;
            presc_q <= PRESC_RELOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        score_q <= '0;
                        presc_q <= PRESC_RELOAD;
                    end
                end
                ST_RUN: begin
                    // lose_i freezes the score at its pre-edge value.
                    if (!lose_i) begin
                        presc_q <= tick ? PRESC_RELOAD : presc_q - PW'(1);
                        score_q <= score_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------- commit: history and high scores
    always_ff @(posedge Clock) begin
        if (!reset) begin
            // NOTE: history and high-score tables are register arrays, not
            // RAM macros, precisely so that reset can clear every entry.
            hist_mem      <= '{default: '0};
            hs_tab        <= '{default: '0};
            wr_ptr_q      <= '0;
            hist_cnt_q    <= '0;
            c0_q          <= 1'b1;
            k_q           <= '0;
            placed_q      <= 1'b0;
            commit_done_q <= 1'b0;
            new_hs_q      <= 1'b0;
        end else begin
            commit_done_q <= 1'b0;
            new_hs_q      <= 1'b0;
            if (state_q != ST_COMMIT) begin
                c0_q <= 1'b1;
            end else if (c0_q) begin
                hist_mem[wr_ptr_q] <= score_q;
                wr_ptr_q           <= wr_ptr_q + HA_W'(1);
                if (hist_cnt_q != (HA_W+1)'(HIST_DEPTH)) begin
                    hist_cnt_q <= hist_cnt_q + (HA_W+1)'(1);
                end
                k_q      <= K_TOP;
                placed_q <= 1'b0;
                c0_q     <= 1'b0;
            end else begin
                // Walk from the bottom up; a strictly greater score pushes the
                // entry at k down one slot, so equal scores keep older ranks.
                if (!placed_q) begin
                    if (score_q > hs_tab[k_q]) begin
                        if (k_q != K_TOP) hs_tab[k_next] <= hs_tab[k_q];
                        if (k_q == '0)    hs_tab[0]      <= score_q;
                    end else begin
                        if (k_q != K_TOP) hs_tab[k_next] <= score_q;
                        placed_q <= 1'b1;
                    end
                end
                k_q <= k_q - HI_W'(1);
                if (k_q == '0) begin
                    commit_done_q <= 1'b1;
                    // hs_tab[0] is only rewritten on this same edge, so this
                    // still compares against the pre-commit best.
                    new_hs_q      <= (score_q > hs_tab[0]);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!reset) hist_rd_q <= '0;
        else        hist_rd_q <= hist_mem[rd_slot];
    end

    always_comb begin
        hs_rd_data_o = '0;
        if (32'(hs_rd_idx_i) < HS_N) hs_rd_data_o = hs_tab[hs_rd_idx_i];
    end

    assign score_o        = score_q;
    assign state_o        = state_q;
    assign hist_rd_data_o = hist_rd_q;
    assign hist_count_o   = hist_cnt_q;
    assign commit_done_o  = commit_done_q;
    assign new_hs_o       = new_hs_q;

`ifdef SCORE_BCD_EN
    score_bcd_conv #(
        .W (SCORE_W)
    ) u_bcd (
        .Clock   (Clock),
        .reset   (reset),
        .bin_i   (score_q),
        .bcd_o   (score_bcd_o),
        .valid_o (bcd_valid_o)
    );
`endif

endmodule
